// File: rtl/reorder_buffer_if.sv
// ============================================================================
// reorder_buffer_if : issue / CDB / query / commit signal bundle of the ROB
// Revision: 1.0
// ============================================================================
`default_nettype none

interface reorder_buffer_if #(
  parameter int TAG_W = 4
);
  logic             in_issue_ena;
  logic [4:0]       in_issue_rd;
  logic             in_issue_is_branch;
  logic             in_issue_pred_taken;
  logic [31:0]      in_issue_fallthrough_pc;
  logic [TAG_W-1:0] out_issue_tag;
  logic             out_full;
  logic             in_cdb_ena;
  logic [TAG_W-1:0] in_cdb_tag;
  logic [31:0]      in_cdb_value;
  logic             in_cdb_taken;
  logic [31:0]      in_cdb_target;
  logic [TAG_W-1:0] in_query_tag1;
  logic [TAG_W-1:0] in_query_tag2;
  logic             out_query_ready1;
  logic             out_query_ready2;
  logic [31:0]      out_query_value1;
  logic [31:0]      out_query_value2;
  logic [4:0]       out_commit_reg;
  logic [TAG_W-1:0] out_commit_tag;
  logic [31:0]      out_commit_value;
  logic             out_rollback;
  logic [31:0]      out_rollback_pc;

  modport master (
    output in_issue_ena, in_issue_rd, in_issue_is_branch, in_issue_pred_taken,
           in_issue_fallthrough_pc, in_cdb_ena, in_cdb_tag, in_cdb_value,
           in_cdb_taken, in_cdb_target, in_query_tag1, in_query_tag2,
    input  out_issue_tag, out_full, out_query_ready1, out_query_ready2,
           out_query_value1, out_query_value2, out_commit_reg, out_commit_tag,
           out_commit_value, out_rollback, out_rollback_pc
  );

  modport slave (
    input  in_issue_ena, in_issue_rd, in_issue_is_branch, in_issue_pred_taken,
           in_issue_fallthrough_pc, in_cdb_ena, in_cdb_tag, in_cdb_value,
           in_cdb_taken, in_cdb_target, in_query_tag1, in_query_tag2,
    output out_issue_tag, out_full, out_query_ready1, out_query_ready2,
           out_query_value1, out_query_value2, out_commit_reg, out_commit_tag,
           out_commit_value, out_rollback, out_rollback_pc
  );
endinterface

`default_nettype wire

// File: rtl/reorder_buffer.sv
// ============================================================================
// reorder_buffer : circular in-order ROB with CDB capture, commit and rollback
// Revision: 1.0
// ============================================================================
`default_nettype none

module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int TAG_W    = 4
) (
  input wire              clk,
  input wire              rst,
  input wire              ena,
  reorder_buffer_if.slave bus
);
  localparam logic [TAG_W-1:0] ONE_TAG  = TAG_W'(1);
  localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(ROB_SIZE - 1);

  logic [ROB_SIZE-1:0] valid_q, valid_d, ready_q, ready_d;
  logic [ROB_SIZE-1:0] is_branch_q, is_branch_d, pred_taken_q, pred_taken_d;
  logic [ROB_SIZE-1:0] taken_q, taken_d;
  logic [4:0]          rd_q      [ROB_SIZE];
  logic [4:0]          rd_d      [ROB_SIZE];
  logic [31:0]         fall_pc_q [ROB_SIZE];
  logic [31:0]         fall_pc_d [ROB_SIZE];
  logic [31:0]         value_q   [ROB_SIZE];
  logic [31:0]         value_d   [ROB_SIZE];
  logic [31:0]         target_q  [ROB_SIZE];
  logic [31:0]         target_d  [ROB_SIZE];

  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic             pend_rb_q, pend_rb_d, rollback_q, rollback_d;
  logic [31:0]      rb_pc_q, rb_pc_d, rollback_pc_q, rollback_pc_d;
  logic [4:0]       commit_reg_q, commit_reg_d;
  logic [TAG_W-1:0] commit_tag_q, commit_tag_d;
  logic [31:0]      commit_value_q, commit_value_d;

  logic full, do_issue, do_cdb, do_commit, mispredict;

  function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
    return (t == LAST_TAG) ? ONE_TAG : t + ONE_TAG;
  endfunction

  // Returns {ready, value}; stored result wins over the same-cycle CDB forward.
  function automatic logic [32:0] lookup(input logic [TAG_W-1:0] t,
                                         input logic hit, input logic [31:0] val,
                                         input logic cdb_en, input logic [TAG_W-1:0] cdb_tag,
                                         input logic [31:0] cdb_val);
    if (t == '0)                   return '0;
    if (hit)                       return {1'b1, val};
    if (cdb_en && (cdb_tag == t))  return {1'b1, cdb_val};
    return '0;
  endfunction

  always_comb begin
    full       = (count_q == LAST_TAG) | pend_rb_q | rollback_q;
    do_issue   = ena & bus.in_issue_ena & ~full;
    do_cdb     = ena & bus.in_cdb_ena & ~pend_rb_q & ~rollback_q & (bus.in_cdb_tag != '0)
                 & valid_q[bus.in_cdb_tag] & ~ready_q[bus.in_cdb_tag];
    do_commit  = ena & ~pend_rb_q & (count_q != '0) & ready_q[head_q];
    mispredict = is_branch_q[head_q] & (taken_q[head_q] != pred_taken_q[head_q]);
  end

  always_comb begin
    valid_d        = valid_q;
    ready_d        = ready_q;
    is_branch_d    = is_branch_q;
    pred_taken_d   = pred_taken_q;
    taken_d        = taken_q;
    rd_d           = rd_q;
    fall_pc_d      = fall_pc_q;
    value_d        = value_q;
    target_d       = target_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    pend_rb_d      = pend_rb_q;
    rb_pc_d        = rb_pc_q;
    rollback_d     = rollback_q;
    rollback_pc_d  = rollback_pc_q;
    commit_reg_d   = commit_reg_q;
    commit_tag_d   = commit_tag_q;
    commit_value_d = commit_value_q;

    if (ena) begin
      if (pend_rb_q) begin
        // Flush one edge after the mispredicted commit so its rd write lands first.
        rollback_d    = 1'b1;
        rollback_pc_d = rb_pc_q;
        valid_d       = '0;
        ready_d       = '0;
        head_d        = ONE_TAG;
        tail_d        = ONE_TAG;
        count_d       = '0;
        pend_rb_d     = 1'b0;
        commit_reg_d  = '0;
        commit_tag_d  = '0;
      end else begin
        rollback_d   = 1'b0;
        commit_reg_d = '0;
        commit_tag_d = '0;
        if (do_commit) begin
          commit_reg_d    = rd_q[head_q];
          commit_tag_d    = head_q;
          commit_value_d  = value_q[head_q];
          valid_d[head_q] = 1'b0;
          ready_d[head_q] = 1'b0;
          head_d          = next_tag(head_q);
          if (mispredict) begin
            pend_rb_d = 1'b1;
            rb_pc_d   = taken_q[head_q] ? target_q[head_q] : fall_pc_q[head_q];
          end
        end
        if (do_cdb) begin
          ready_d[bus.in_cdb_tag]  = 1'b1;
          value_d[bus.in_cdb_tag]  = bus.in_cdb_value;
          taken_d[bus.in_cdb_tag]  = bus.in_cdb_taken;
          target_d[bus.in_cdb_tag] = bus.in_cdb_target;
        end
        if (do_issue) begin
          valid_d[tail_q]      = 1'b1;
          ready_d[tail_q]      = 1'b0;
          rd_d[tail_q]         = bus.in_issue_rd;
          is_branch_d[tail_q]  = bus.in_issue_is_branch;
          pred_taken_d[tail_q] = bus.in_issue_pred_taken;
          fall_pc_d[tail_q]    = bus.in_issue_fallthrough_pc;
          tail_d               = next_tag(tail_q);
        end
        case ({do_issue, do_commit})
          2'b10:   count_d = count_q + ONE_TAG;
          2'b01:   count_d = count_q - ONE_TAG;
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= '0;
      ready_q        <= '0;
      head_q         <= ONE_TAG;
      tail_q         <= ONE_TAG;
      count_q        <= '0;
      pend_rb_q      <= 1'b0;
      rb_pc_q        <= '0;
      rollback_q     <= 1'b0;
      rollback_pc_q  <= '0;
      commit_reg_q   <= '0;
      commit_tag_q   <= '0;
      commit_value_q <= '0;
    end else begin
      valid_q        <= valid_d;
      ready_q        <= ready_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      pend_rb_q      <= pend_rb_d;
      rb_pc_q        <= rb_pc_d;
      rollback_q     <= rollback_d;
      rollback_pc_q  <= rollback_pc_d;
      commit_reg_q   <= commit_reg_d;
      commit_tag_q   <= commit_tag_d;
      commit_value_q <= commit_value_d;
    end
  end

  // Payload is qualified by valid/ready, so it needs no reset.
  always_ff @(posedge clk) begin
    is_branch_q  <= is_branch_d;
    pred_taken_q <= pred_taken_d;
    taken_q      <= taken_d;
    rd_q         <= rd_d;
    fall_pc_q    <= fall_pc_d;
    value_q      <= value_d;
    target_q     <= target_d;
  end

  logic [32:0] q1, q2;
  assign q1 = lookup(bus.in_query_tag1, valid_q[bus.in_query_tag1] & ready_q[bus.in_query_tag1],
                     value_q[bus.in_query_tag1], bus.in_cdb_ena, bus.in_cdb_tag, bus.in_cdb_value);
  assign q2 = lookup(bus.in_query_tag2, valid_q[bus.in_query_tag2] & ready_q[bus.in_query_tag2],
                     value_q[bus.in_query_tag2], bus.in_cdb_ena, bus.in_cdb_tag, bus.in_cdb_value);

  assign bus.out_issue_tag    = tail_q;
  assign bus.out_full         = full;
  assign bus.out_query_ready1 = q1[32];
  assign bus.out_query_value1 = q1[31:0];
  assign bus.out_query_ready2 = q2[32];
  assign bus.out_query_value2 = q2[31:0];
  assign bus.out_commit_reg   = commit_reg_q;
  assign bus.out_commit_tag   = commit_tag_q;
  assign bus.out_commit_value = commit_value_q;
  assign bus.out_rollback     = rollback_q;
  assign bus.out_rollback_pc  = rollback_pc_q;
endmodule

`default_nettype wire
